frame_buffer_writer: RTL

Writer side of the thresholding frame buffer. Accepts the RGB565 camera pixel stream, converts each pixel to a 12-bit luminance value, crops it to the stored image window, and issues single-port BRAM writes. The display-side threshold renderer reads the frame buffer this block fills. Capture is request-driven: one-shot snapshot or continuous refresh, with a frame-complete pulse.

---
 rtl/frame_buffer_writer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer
// Writer side of the thresholding frame buffer. Converts the RGB565 camera
// stream to 12-bit luminance, crops it to the stored window and issues
// single-port BRAM writes. Capture is request-driven (one-shot or continuous)
// and a frame_done_out pulse follows the last write of each complete frame.
//
// Two-stage pipeline: camera_valid_in at cycle N -> bram_we_out at N+2,
// frame_done_out at N+3 for the last pixel of the window.
//
// Optional build macro: FBW_MIRROR_EN mirrors the stored x coordinate so the
// image appears as a mirror on the display. Last-pixel and lost-sync
// detection keep using the raw camera coordinates.

module frame_buffer_writer #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 320,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              camera_valid_in,
  input  logic [10:0]       camera_hcount_in,
  input  logic [9:0]        camera_vcount_in,
  input  logic [15:0]       camera_pixel_in,
  input  logic              capture_in,
  input  logic              continuous_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [11:0]       bram_data_out,
  output logic              bram_we_out,
  output logic              busy_out,
  output logic              frame_done_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
  localparam logic [9:0]  Y_LAST = 10'(IMG_HEIGHT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        w_origin;
  logic        w_in_window;
  logic        w_is_last;
  logic        w_write;
  logic        w_frame_end;

  // Stage 1 registers
  logic        r_s1_we;
  logic        r_s1_last;
  logic [15:0] r_s1_pixel;
  logic [10:0] r_s1_hcount;
  logic [9:0]  r_s1_vcount;

  // Stage 2 side-band: marks the final write of a frame
  logic        r_s2_last;

  logic [7:0]        w_sum;
  logic [5:0]        w_r6;
  logic [5:0]        w_g6;
  logic [5:0]        w_b6;
  logic [31:0]       w_x_store;
  logic [ADDR_W-1:0] w_addr;

  // Raw-coordinate decodes of the incoming pixel
  assign w_origin    = camera_valid_in && (camera_hcount_in == 11'd0) &&
                       (camera_vcount_in == 10'd0);
  assign w_in_window = camera_valid_in && (camera_hcount_in <= X_LAST) &&
                       (camera_vcount_in <= Y_LAST);
  assign w_is_last   = w_in_window && (camera_hcount_in == X_LAST) &&
                       (camera_vcount_in == Y_LAST);

  // Next-state and write-qualifier decode, evaluated against the current state
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_write      = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (capture_in) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_origin) begin
          w_write      = 1'b1;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // A (0,0) pixel here is a resync: it is simply written to address 0
        // and the state is left alone, so the aborted frame never signals done.
        w_write = w_in_window;
        if (w_is_last) begin
          w_frame_end  = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = continuous_in ? ST_ARMED : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Capture state machine; busy is registered alongside the state it reflects
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_in) begin
      r_state  <= ST_IDLE;
      busy_out <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      busy_out <= (w_state_next == ST_ARMED) || (w_state_next == ST_CAPTURE);
    end
  end

  // Stage 1: register pixel, coordinates and the write qualifier
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_we     <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_pixel  <= 16'd0;
      r_s1_hcount <= 11'd0;
      r_s1_vcount <= 10'd0;
    end else begin
      r_s1_we     <= w_write;
      r_s1_last   <= w_frame_end;
      r_s1_pixel  <= camera_pixel_in;
      r_s1_hcount <= camera_hcount_in;
      r_s1_vcount <= camera_vcount_in;
    end
  end

  // Luminance: red and blue widened to 6 bits by replicating their MSB
  assign w_r6  = {r_s1_pixel[15:11], r_s1_pixel[15]};
  assign w_g6  = r_s1_pixel[10:5];
  assign w_b6  = {r_s1_pixel[4:0], r_s1_pixel[4]};
  assign w_sum = {2'b00, w_r6} + {1'b0, w_g6, 1'b0} + {2'b00, w_b6};

  // Stored column; only in-window pixels are written, so the mirror never wraps
`ifdef FBW_MIRROR_EN
  assign w_x_store = 32'(IMG_WIDTH - 1) - 32'(r_s1_hcount);
`else
  assign w_x_store = 32'(r_s1_hcount);
`endif

  assign w_addr = ADDR_W'(32'(r_s1_vcount) * 32'(IMG_WIDTH) + w_x_store);

  // Stage 2: register BRAM address, data and write enable
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bram_we_out   <= 1'b0;
      bram_addr_out <= '0;
      bram_data_out <= 12'd0;
      r_s2_last     <= 1'b0;
    end else begin
      bram_we_out   <= r_s1_we;
      bram_addr_out <= w_addr;
      bram_data_out <= {w_sum, w_sum[7:4]};
      r_s2_last     <= r_s1_last;
    end
  end

  // Frame-complete pulse, one cycle after the final write
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= r_s2_last;
    end
  end

endmodule
